// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the hazard sequencer and the pipeline datapath.
// The datapath side (master) supplies hazard sources; the sequencer (slave) returns stage controls.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             mem_branch_taken;
  logic             mem_busy;

  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             exmem_we;
  logic             memwb_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             pc_sel_branch;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_branch_taken, mem_busy,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           pc_sel_branch, ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_branch_taken, mem_busy,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           pc_sel_branch, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, MEM-resolved
// branch redirects, data-memory freezes, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    UNUSED   = 2'd3
  } state_t;

  localparam logic [2:0]       LU_INIT = 3'(LOAD_USE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [2:0]       lu_cnt, lu_cnt_nxt;
  logic             hazard;
  logic             branch_go;
  logic [4:0]       we;
  logic [3:0]       flush;
  logic             sel_branch;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign hazard = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                  ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
  assign branch_go = !bus.mem_busy && bus.mem_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      lu_cnt <= 3'd0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  // A freeze holds an in-progress load-use stall; MEM_WAIT and the unused code fall through as RUN.
  always_comb begin
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    if (bus.mem_busy) begin
      if (state != LU_STALL) state_nxt = MEM_WAIT;
    end else if (bus.mem_branch_taken) begin
      state_nxt  = RUN;
      lu_cnt_nxt = 3'd0;
    end else if (state == LU_STALL) begin
      if (lu_cnt <= 3'd1) begin
        state_nxt  = RUN;
        lu_cnt_nxt = 3'd0;
      end else begin
        lu_cnt_nxt = lu_cnt - 3'd1;
      end
    end else if (hazard && (LOAD_USE_CYCLES > 1)) begin
      state_nxt  = LU_STALL;
      lu_cnt_nxt = LU_INIT;
    end else begin
      state_nxt = RUN;
    end
  end

  // we = {pc, ifid, idex, exmem, memwb}; flush = {ifid, idex, exmem, memwb}
  always_comb begin
    we         = 5'b11111;
    flush      = 4'b0000;
    sel_branch = 1'b0;
    if (rst) begin
      we    = 5'b00000;
      flush = 4'b1111;
    end else if (bus.mem_busy) begin
      we    = 5'b00000;
      flush = 4'b0001;
    end else if (bus.mem_branch_taken) begin
      flush      = 4'b1110;
      sel_branch = 1'b1;
    end else if ((state == LU_STALL) || hazard) begin
      we    = 5'b00111;
      flush = 4'b0100;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!we[4] && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (branch_go && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.pc_we         = we[4];
  assign bus.ifid_we       = we[3];
  assign bus.idex_we       = we[2];
  assign bus.exmem_we      = we[1];
  assign bus.memwb_we      = we[0];
  assign bus.ifid_flush    = flush[3];
  assign bus.idex_flush    = flush[2];
  assign bus.exmem_flush   = flush[1];
  assign bus.memwb_flush   = flush[0];
  assign bus.pc_sel_branch = sel_branch;
  assign bus.ctrl_state    = state;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.flush_cnt     = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Drives two sequencers (1-cycle/16-bit and 3-cycle/4-bit) with shared stimulus
// and compares both against a per-hazard stall-budget model.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus0();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  bus1();

  pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int luCycles [2] = '{1, 3};
  int cntMax   [2] = '{65535, 15};
  int stallLeft [2];
  bit waiting   [2];
  int stallsExp [2];
  int flushesExp[2];

  bit       curRst, curUsesRt, curMemRead, curBr, curBusy;
  bit [4:0] curRs, curRt, curExRt;

  logic [9:0]  obsCtrl  [2];
  logic [1:0]  obsState [2];
  logic [15:0] obsStall [2];
  logic [15:0] obsFlush [2];

  assign obsCtrl[0]  = {bus0.pc_we, bus0.ifid_we, bus0.idex_we, bus0.exmem_we, bus0.memwb_we,
                        bus0.ifid_flush, bus0.idex_flush, bus0.exmem_flush, bus0.memwb_flush,
                        bus0.pc_sel_branch};
  assign obsCtrl[1]  = {bus1.pc_we, bus1.ifid_we, bus1.idex_we, bus1.exmem_we, bus1.memwb_we,
                        bus1.ifid_flush, bus1.idex_flush, bus1.exmem_flush, bus1.memwb_flush,
                        bus1.pc_sel_branch};
  assign obsState[0] = bus0.ctrl_state;
  assign obsState[1] = bus1.ctrl_state;
  assign obsStall[0] = bus0.stall_cnt;
  assign obsStall[1] = {12'd0, bus1.stall_cnt};
  assign obsFlush[0] = bus0.flush_cnt;
  assign obsFlush[1] = {12'd0, bus1.flush_cnt};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit [4:0] rs, input bit [4:0] rt, input bit usesRt,
                               input bit memRead, input bit [4:0] exRt, input bit br, input bit busy);
    curRst = r; curRs = rs; curRt = rt; curUsesRt = usesRt;
    curMemRead = memRead; curExRt = exRt; curBr = br; curBusy = busy;
    rst = r;
    bus0.id_rs = rs; bus0.id_rt = rt; bus0.id_uses_rt = usesRt; bus0.ex_mem_read = memRead;
    bus0.ex_rt = exRt; bus0.mem_branch_taken = br; bus0.mem_busy = busy;
    bus1.id_rs = rs; bus1.id_rt = rt; bus1.id_uses_rt = usesRt; bus1.ex_mem_read = memRead;
    bus1.ex_rt = exRt; bus1.mem_branch_taken = br; bus1.mem_busy = busy;
  endtask

  // Expected {5 we, 4 flush, sel} from the event priority rst > busy > branch > stall
  function automatic logic [9:0] expCtrl(input bit r, input bit busy, input bit br, input bit stalling);
    if (r)             return 10'b00000_1111_0;
    else if (busy)     return 10'b00000_0001_0;
    else if (br)       return 10'b11111_1110_1;
    else if (stalling) return 10'b00111_0100_0;
    else               return 10'b11111_0000_0;
  endfunction

  task automatic checkAll();
    bit haz;
    haz = curMemRead && (curExRt != 0) && ((curExRt == curRs) || (curUsesRt && (curExRt == curRt)));
    for (int d = 0; d < 2; d++) begin
      logic [9:0] e;
      int expState;
      if (curRst) begin
        stallLeft[d] = 0; waiting[d] = 0; stallsExp[d] = 0; flushesExp[d] = 0;
      end
      e = expCtrl(curRst, curBusy, curBr, (stallLeft[d] > 0) || haz);
      expState = (stallLeft[d] > 0) ? 1 : (waiting[d] ? 2 : 0);
      checkOutput($sformatf("ctrl%0d", d),  32'(obsCtrl[d]),  32'(e));
      checkOutput($sformatf("state%0d", d), 32'(obsState[d]), 32'(expState));
      checkOutput($sformatf("stall%0d", d), 32'(obsStall[d]), 32'(stallsExp[d]));
      checkOutput($sformatf("flush%0d", d), 32'(obsFlush[d]), 32'(flushesExp[d]));
      if (!curRst) begin
        if (!e[9] && stallsExp[d] < cntMax[d]) stallsExp[d]++;
        if (!curBusy && curBr && flushesExp[d] < cntMax[d]) flushesExp[d]++;
        if (curBusy) begin
          if (stallLeft[d] == 0) waiting[d] = 1;
        end else begin
          waiting[d] = 0;
          if (curBr)                  stallLeft[d] = 0;
          else if (stallLeft[d] > 0)  stallLeft[d]--;
          else if (haz)               stallLeft[d] = luCycles[d] - 1;
        end
      end
    end
  endtask

  task automatic runCycle(input bit r, input bit [4:0] rs, input bit [4:0] rt, input bit usesRt,
                          input bit memRead, input bit [4:0] exRt, input bit br, input bit busy);
    @(negedge clk);
    applyStimulus(r, rs, rt, usesRt, memRead, exRt, br, busy);
    #2;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) runCycle(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Load-use on rs, then the same with ex_rt=0 which must not stall
    runCycle(0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    idle(4);
    runCycle(0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(1);

    // Load-use on rt, then rt match ignored when id_uses_rt=0
    runCycle(0, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    idle(4);
    runCycle(0, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    idle(1);

    // Branch beats a simultaneous hazard, and aborts a pending stall
    runCycle(0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    idle(1);
    runCycle(0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    runCycle(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(2);

    // Freeze from RUN, then freeze inside LU_STALL
    for (int i = 0; i < 3; i++) runCycle(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(1);
    runCycle(0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    runCycle(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    runCycle(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(4);

    // Asynchronous reset while the 3-cycle instance is in LU_STALL
    runCycle(0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("lustall_pre", 32'(obsState[1]), 32'd1);
    #1;
    applyStimulus(1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkAll();
    runCycle(1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(2);

    // Long freeze saturates the 4-bit stall counter
    for (int i = 0; i < 20; i++) runCycle(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(2);
    checkOutput("stall_sat", 32'(obsStall[1]), 32'd15);

    // Randomized traffic with small register numbers to provoke matches
    for (int i = 0; i < 1500; i++) begin
      bit r, busy, br, usesRt, memRead;
      bit [4:0] rs, rt, exRt;
      r       = ($urandom_range(0, 199) == 0);
      busy    = ($urandom_range(0, 99) < 15);
      br      = ($urandom_range(0, 99) < 8);
      usesRt  = $urandom_range(0, 1) == 1;
      memRead = ($urandom_range(0, 99) < 45);
      rs      = 5'($urandom_range(0, 3));
      rt      = 5'($urandom_range(0, 3));
      exRt    = 5'($urandom_range(0, 3));
      runCycle(r, rs, rt, usesRt, memRead, exRt, br, busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
